// File: rtl/rs_encoder_if.sv
// Stream interface for rs_encoder: message symbols in, codeword symbols out,
// plus the frame-length error pulse.
interface rs_encoder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       err;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, err
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, err
  );
endinterface

// File: rtl/rs_encoder.sv
// Systematic RS(K+6, K) encoder over GF(2^8), poly 0x11D, g(x) = prod (x + a^i), i = 1..6.
// Message symbols pass straight through; six parity symbols follow, P5 first.
// Optional feature macro: RS_ENC_LAST_CHECK_EN (in_last vs. counter frame-length check on err).
module rs_encoder #(
  parameter int K = 249
) (
  input  logic         clk,
  input  logic         rst_n,
  rs_encoder_if.slave  bus
);
  // Monic generator coefficients g5..g0 (x^6 term implicit).
  localparam logic [5:0][7:0] G = {8'h7E, 8'h04, 8'h9E, 8'h3A, 8'h31, 8'h75};
  localparam logic [7:0]      LAST_CNT = 8'(K - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t          state, state_nx;
  logic [7:0]      count, count_nx;
  logic [2:0]      pcnt, pcnt_nx;
  logic [5:0][7:0] r, r_nx;
  logic [7:0]      data_q, data_nx;
  logic            valid_q, valid_nx, last_q, last_nx, err_q, err_nx;
  logic            load, rdy, accept;
  logic [7:0]      fb;

  // GF(2^8) multiply mod 0x11D; with a constant operand this folds to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  assign load   = !valid_q || bus.out_ready;
  assign rdy    = (state != PARITY) && load;
  assign accept = bus.in_valid && rdy;
  assign fb     = bus.in_data ^ r[5];

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.err       = err_q;

`ifndef RS_ENC_LAST_CHECK_EN
  logic unused_last;
  assign unused_last = bus.in_last;
`endif

  // Next-state: message accept feeds the LFSR, parity phase shifts it out.
  always_comb begin
    state_nx = state;
    count_nx = count;
    pcnt_nx  = pcnt;
    r_nx     = r;
    data_nx  = data_q;
    valid_nx = valid_q;
    last_nx  = last_q;
    err_nx   = 1'b0;
    if (load) begin
      valid_nx = 1'b0;
      last_nx  = 1'b0;
    end
    if (state == PARITY) begin
      if (load) begin
        data_nx  = r[5];
        valid_nx = 1'b1;
        r_nx     = {r[4:0], 8'h00};
        pcnt_nx  = pcnt + 3'd1;
        if (pcnt == 3'd5) begin
          last_nx  = 1'b1;
          state_nx = IDLE;
          r_nx     = '0;
          pcnt_nx  = '0;
          count_nx = '0;
        end
      end
    end else if (accept) begin
      data_nx  = bus.in_data;
      valid_nx = 1'b1;
      r_nx[0]  = gf_mul(fb, G[0]);
      for (int i = 1; i < 6; i++) r_nx[i] = r[i-1] ^ gf_mul(fb, G[i]);
      if (count == LAST_CNT) begin
        state_nx = PARITY;
        count_nx = '0;
      end else begin
        state_nx = DATA;
        count_nx = count + 8'd1;
      end
`ifdef RS_ENC_LAST_CHECK_EN
      // Flag a marker on the wrong symbol, or a missing marker on the K-th.
      err_nx = bus.in_last ^ (count == LAST_CNT);
`endif
    end
  end

  // State, LFSR and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      pcnt    <= '0;
      r       <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      pcnt    <= pcnt_nx;
      r       <= r_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      last_q  <= last_nx;
      err_q   <= err_nx;
    end
  end
endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon encoder over GF(2^8): primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02. It produces six parity symbols per frame, so the code corrects t = 3 symbol errors. The generator is g(x) = (x+α)(x+α²)…(x+α⁶), which makes the decoder's syndromes S1..S6 zero for an error-free codeword. The block sits at the transmit end of the channel: it takes a K-symbol message stream and emits K message symbols followed by 6 parity symbols.

## Interface
- K, 249, message symbols per frame; legal range 1..249.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  message symbol; first symbol is the highest-degree coefficient.
- in_valid  in  1  in_data valid.
- in_ready  out  1  encoder can accept a symbol this cycle.
- in_last  in  1  marks the final message symbol; used only with RS_ENC_LAST_CHECK_EN.
- out_data  out  8  codeword symbol.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts a symbol this cycle.
- out_last  out  1  high on the 6th parity symbol.
- err  out  1  one-cycle frame-length error pulse.

## Operation
- State machine:
  - IDLE: symbol count = 0, LFSR = 0.
  - DATA: message symbols 1..K-1 accepted.
  - PARITY: parity symbols being emitted.
- Output register can load when `!out_valid || out_ready`.
- in_ready = `(state != PARITY) && (output register can load)`.
- Accept (in_valid && in_ready):
  - out_data ← in_data.
  - fb = in_data ^ r5.
  - LFSR update: r_i ← r_(i-1) ^ gf_mul(fb, g_i) for i = 1..5; r0 ← gf_mul(fb, g0).
  - g5..g0 are elaboration-time constants of monic g(x).
- Transitions:
  - IDLE → DATA on the first accept.
  - Accept of symbol K (count = K-1) → PARITY. When K = 1 this is IDLE → PARITY directly.
- PARITY: on each output-register load:
  - out_data ← r5.
  - Shift r_i ← r_(i-1), r0 ← 0.
  - Parity order is P5 first, P0 last.
  - The 6th load sets out_last and moves the state to IDLE with LFSR and count cleared.
- Message symbols pass through unchanged (systematic code).
- gf_mul is combinational GF(2^8) multiplication modulo 0x11D. Addition is XOR.
- Frame length is always taken from the counter. in_last never truncates or extends a frame.

## Timing
- Reset values (asynchronous, immediate):
  - out_valid = 0, out_data = 0x00, out_last = 0, err = 0.
  - state = IDLE, count = 0, r0..r5 = 0.
- Latency: a symbol accepted in cycle n appears on out_data in cycle n+1.
- P5 is loaded the cycle after the K-th accept. It loads only if out_ready allows; otherwise the load stalls.
- in_ready is low from the cycle after the K-th accept until the cycle after the 6th parity load.
- With out_ready held high and in_valid held high:
  - one frame every K+6 cycles, no bubbles;
  - the next frame's first symbol is accepted the cycle after P0 is loaded.
- Backpressure: when out_ready is low and out_valid is high:
  - out_data, out_valid and out_last hold;
  - the LFSR, counter and state do not advance.
- in_valid low in DATA: the frame pauses. There is no timeout.
- Reset mid-frame: the partial frame is discarded and no parity is emitted. The first accept after reset starts a new frame.

## Configuration
- RS_ENC_LAST_CHECK_EN defined:
  - err pulses high for one cycle, in the cycle after an accept, when in_last is high with count ≠ K-1.
  - err also pulses when in_last is low on the K-th symbol.
  - Encoding is unaffected by err.
- Not defined: in_last is ignored and err is tied 0.

## Test plan
- All-zero message, K = 249, out_ready = 1 → 249 output symbols of 0x00, then P5..P0 = 0x00. out_last is high on beat 255 only.
- Message of 248 zeros then 0x01 → parity P5..P0 = g5..g0; the codeword equals g(x).
- Random 249-symbol messages, 1000 frames, fed through a reference syndrome model → S1..S6 = 0 for every codeword. Downstream sigma outputs s1 = s2 = s3 = 0.
- Random out_ready (50 % duty) and in_valid gaps → the codeword stream is identical to the no-stall run, with no dropped or duplicated beats.
- rst_n asserted after 100 accepts → out_valid = 0 immediately. The next frame encodes as if fresh: all-zero message → zero parity.
- With RS_ENC_LAST_CHECK_EN and K = 4:
  - in_last on symbol 2 → err pulse on the cycle after that accept;
  - in_last on symbol 4 → no err;
  - K = 1 frame → P5..P0 emitted directly after the single symbol.
